// File: rtl/wifi_tx_pkg.sv
// wifi_tx_pkg: OFDM subcarrier layout, pilot levels and read FSM states shared across the WiFi TX chain.
package wifi_tx_pkg;
    localparam int N_FFT  = 64;
    localparam int N_DATA = 48;
    localparam logic [5:0] PILOT_BIN_P7  = 6'd7;
    localparam logic [5:0] PILOT_BIN_P21 = 6'd21;
    localparam logic [5:0] PILOT_BIN_M21 = 6'd43;
    localparam logic [5:0] PILOT_BIN_M7  = 6'd57;
    localparam logic [5:0] GUARD_LO      = 6'd27;
    localparam logic [5:0] GUARD_HI      = 6'd37;
    localparam logic [11:0] PILOT_POS = 12'h200;
    localparam logic [11:0] PILOT_NEG = 12'hE00;

    typedef enum logic {RD_IDLE, RD_READ} rd_state_t;

    // Data index 0..47 walks k = -26..26 skipping DC and the four pilots; bin = k mod 64.
    function automatic logic [5:0] data_bin(input logic [5:0] d);
        return d < 6'd5  ? d + 6'd38 :
               d < 6'd18 ? d + 6'd39 :
               d < 6'd24 ? d + 6'd40 :
               d < 6'd30 ? d - 6'd23 :
               d < 6'd43 ? d - 6'd22 : d - 6'd21;
    endfunction
endpackage

// File: rtl/wifi_tx_pilot_insert_if.sv
// wifi_tx_pilot_insert_if: mapper-side symbol stream in, IFFT-side subcarrier stream out.
interface wifi_tx_pilot_insert_if #(parameter int DATA_WIDTH = 12);
    logic                  valid_in;
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] data_in_real;
    logic [DATA_WIDTH-1:0] data_in_imag;
    logic                  valid_out;
    logic                  sym_start;
    logic [5:0]            bin_idx;
    logic [DATA_WIDTH-1:0] data_out_real;
    logic [DATA_WIDTH-1:0] data_out_imag;
    logic                  overflow;

    modport master (
        output valid_in, frame_start, data_in_real, data_in_imag,
        input  valid_out, sym_start, bin_idx, data_out_real, data_out_imag, overflow
    );
    modport slave (
        input  valid_in, frame_start, data_in_real, data_in_imag,
        output valid_out, sym_start, bin_idx, data_out_real, data_out_imag, overflow
    );
endinterface

// File: rtl/wifi_tx_pilot_lfsr.sv
// wifi_tx_pilot_lfsr: x^7+x^4+1 pilot polarity scrambler; pol=1 means inverted pilots.
module wifi_tx_pilot_lfsr (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic advance,
    output logic pol
);
    logic [6:0] s;

    assign pol = s[6] ^ s[3];

    always_ff @(posedge clk) begin
        if (reset || load) s <= '1;
        else if (advance)  s <= {s[5:0], pol};
    end
endmodule

// File: rtl/wifi_tx_pilot_insert.sv
// wifi_tx_pilot_insert: ping-pong buffers 48 mapped symbols, then streams 64 IFFT bins
// with scrambled pilots and nulled DC/guards.
module wifi_tx_pilot_insert
    import wifi_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int PILOT_AMP  = 512
) (
    input logic clk,
    input logic reset,
    wifi_tx_pilot_insert_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] P_POS = DATA_WIDTH'(PILOT_AMP);
    localparam logic [DATA_WIDTH-1:0] P_NEG = DATA_WIDTH'(-PILOT_AMP);

    // Banks are stored by IFFT bin so the reader just walks addresses 0..63.
    logic [2*DATA_WIDTH-1:0] mem [2*N_FFT];
    logic [1:0]              full, frame_first;
    logic                    wr_bank, wr_ok, wr_last;
    logic [5:0]              wr_ptr, wr_idx;
    rd_state_t               state, state_n;
    logic                    rd_bank, rd_bank_n, burst_start, burst_end, pol;
    logic [5:0]              cnt, cnt_n;
    logic [2*DATA_WIDTH-1:0] rd_word;
    logic                    is_null, is_pilot_pos, is_pilot_neg;
    logic [DATA_WIDTH-1:0]   re_n, im_n;

    assign wr_idx  = bus.frame_start ? '0 : wr_ptr;
    assign wr_ok   = bus.valid_in & ~full[wr_bank];
    assign wr_last = wr_ok && wr_idx == 6'(N_DATA - 1);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[{wr_bank, data_bin(wr_idx)}] <= {bus.data_in_real, bus.data_in_imag};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            wr_bank      <= 1'b0;
            full         <= '0;
            frame_first  <= '0;
            bus.overflow <= 1'b0;
        end else begin
            if (burst_end) full[rd_bank] <= 1'b0;
            if (bus.valid_in && full[wr_bank]) bus.overflow <= 1'b1;
            if (wr_ok) begin
                wr_ptr  <= wr_last ? '0 : wr_idx + 6'd1;
                wr_bank <= wr_last ? ~wr_bank : wr_bank;
                if (wr_idx == '0) frame_first[wr_bank] <= bus.frame_start;
                if (wr_last) full[wr_bank] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RD_IDLE;
            cnt     <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rd_bank <= rd_bank_n;
        end
    end

    // When both banks are full the one awaiting the next write is the older one.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        rd_bank_n   = rd_bank;
        burst_start = 1'b0;
        burst_end   = 1'b0;
        case (state)
            RD_IDLE: if (|full) begin
                state_n     = RD_READ;
                cnt_n       = '0;
                rd_bank_n   = &full ? wr_bank : full[1];
                burst_start = 1'b1;
            end
            RD_READ: begin
                cnt_n = cnt + 6'd1;
                if (cnt == 6'(N_FFT - 1)) begin
                    burst_end   = 1'b1;
                    burst_start = full[~rd_bank];
                    rd_bank_n   = full[~rd_bank] ? ~rd_bank : rd_bank;
                    state_n     = full[~rd_bank] ? RD_READ : RD_IDLE;
                end
            end
            default: state_n = RD_IDLE;
        endcase
    end

    wifi_tx_pilot_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (burst_start & frame_first[rd_bank_n]),
        .advance (burst_end),
        .pol     (pol)
    );

    always_comb begin
        rd_word      = mem[{rd_bank, cnt}];
        is_null      = cnt == '0 || (cnt >= GUARD_LO && cnt <= GUARD_HI);
        is_pilot_pos = cnt == PILOT_BIN_P7 || cnt == PILOT_BIN_M21 || cnt == PILOT_BIN_M7;
        is_pilot_neg = cnt == PILOT_BIN_P21;
        re_n = is_null      ? '0 :
               is_pilot_pos ? (pol ? P_NEG : P_POS) :
               is_pilot_neg ? (pol ? P_POS : P_NEG) : rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
        im_n = (is_null || is_pilot_pos || is_pilot_neg) ? '0 : rd_word[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.valid_out     <= 1'b0;
            bus.sym_start     <= 1'b0;
            bus.bin_idx       <= '0;
            bus.data_out_real <= '0;
            bus.data_out_imag <= '0;
        end else begin
            bus.valid_out     <= state == RD_READ;
            bus.sym_start     <= state == RD_READ && cnt == '0;
            bus.bin_idx       <= state == RD_READ ? cnt : '0;
            bus.data_out_real <= state == RD_READ ? re_n : '0;
            bus.data_out_imag <= state == RD_READ ? im_n : '0;
        end
    end
endmodule

// File: tb/tb_wifi_tx_pilot_insert.sv
// tb_wifi_tx_pilot_insert: directed vectors for pilot insertion, ping-pong flow, overflow and reset abort.
module tb_wifi_tx_pilot_insert;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wifi_tx_pilot_insert_if #(.DATA_WIDTH(12)) bus ();
    wifi_tx_pilot_insert #(.DATA_WIDTH(12), .PILOT_AMP(512)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0, miscompares = 0;
    int nb = 0, nstart = 0, seq_err = 0;
    logic prev_vo = 1'b0;
    int p7[32], p21[32], b1[32];

    // Per-burst capture of the bins the directed checks care about.
    always @(negedge clk) begin
        if (bus.valid_out) begin
            if (bus.sym_start != (bus.bin_idx == 6'd0)) seq_err <= seq_err + 1;
            if (bus.bin_idx == 6'd7)  p7[nb % 32]  <= int'($signed(bus.data_out_real));
            if (bus.bin_idx == 6'd21) p21[nb % 32] <= int'($signed(bus.data_out_real));
            if (bus.bin_idx == 6'd1)  b1[nb % 32]  <= int'($signed(bus.data_out_real));
            if (bus.bin_idx == 6'd63) nb <= nb + 1;
            if (!prev_vo) nstart <= nstart + 1;
        end else if (bus.sym_start || bus.bin_idx != 6'd0 || bus.data_out_real != '0 || bus.data_out_imag != '0) begin
            seq_err <= seq_err + 1;
        end
        prev_vo <= bus.valid_out;
    end

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input int n, input bit fs, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.valid_in     = 1'b1;
            bus.frame_start  = fs && i == 0;
            bus.data_in_real = 12'(base + i);
            bus.data_in_imag = 12'(-(base + i));
        end
        @(negedge clk);
        bus.valid_in    = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_nb(input int target, input string tag);
        for (int k = 0; k < 400 && nb < target; k++) @(posedge clk);
        @(posedge clk);
        chk(tag, nb, target);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cre[64], cim[64];
        int berr, gerr, nb0, ns0;
        int exp_p[9];
        bus.valid_in = 1'b0;
        bus.frame_start = 1'b0;
        bus.data_in_real = '0;
        bus.data_in_imag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_bin", int'(bus.bin_idx), 0);
        chk("rst_re", int'(bus.data_out_real), 0);
        @(negedge clk);
        reset = 1'b0;

        // One symbol, d_i = (i, -i): latency and full bin map.
        send(48, 1'b1, 0);
        @(posedge clk); #1;
        chk("lat_t1_valid", int'(bus.valid_out), 0);
        @(posedge clk); #1;
        chk("lat_t2_valid", int'(bus.valid_out), 1);
        chk("lat_t2_sym_start", int'(bus.sym_start), 1);
        berr = 0;
        for (int b = 0; b < 64; b++) begin
            cre[b] = int'($signed(bus.data_out_real));
            cim[b] = int'($signed(bus.data_out_imag));
            if (bus.bin_idx != 6'(b) || !bus.valid_out) berr++;
            @(posedge clk); #1;
        end
        chk("burst_bin_seq", berr, 0);
        chk("after_burst_valid", int'(bus.valid_out), 0);
        chk("bin0_re", cre[0], 0);
        chk("bin0_im", cim[0], 0);
        chk("bin1_re", cre[1], 24);
        chk("bin1_im", cim[1], -24);
        chk("bin7_re", cre[7], 512);
        chk("bin7_im", cim[7], 0);
        chk("bin21_re", cre[21], -512);
        gerr = 0;
        for (int b = 27; b <= 37; b++) if (cre[b] != 0 || cim[b] != 0) gerr++;
        chk("guard_nonzero", gerr, 0);
        chk("bin38_re", cre[38], 0);
        chk("bin43_re", cre[43], 512);
        chk("bin44_im", cim[44], -5);
        chk("bin57_re", cre[57], 512);
        chk("bin63_re", cre[63], 23);
        chk("bin63_im", cim[63], -23);

        // Nine symbols at 48-of-64 duty: polarity sequence and gapless bursts.
        nb0 = nb;
        ns0 = nstart;
        exp_p = '{512, 512, 512, 512, -512, -512, -512, 512, -512};
        for (int j = 0; j < 9; j++) begin
            send(48, j == 0, j * 50);
            repeat (15) @(negedge clk);
        end
        wait_nb(nb0 + 9, "duty_bursts");
        for (int j = 0; j < 9; j++) chk($sformatf("p7_burst%0d", j), p7[(nb0 + j) % 32], exp_p[j]);
        chk("p21_burst4", p21[(nb0 + 4) % 32], 512);
        chk("duty_b1_burst8", b1[(nb0 + 8) % 32], 424);
        chk("duty_starts", nstart - ns0, 1);
        chk("duty_ovf", int'(bus.overflow), 0);

        // New frame after a partial symbol: discard and LFSR reload.
        nb0 = nb;
        send(20, 1'b0, 1000);
        send(48, 1'b1, 300);
        wait_nb(nb0 + 1, "restart_bursts");
        chk("restart_b1", b1[nb0 % 32], 324);
        chk("restart_p7", p7[nb0 % 32], 512);
        chk("restart_p21", p21[nb0 % 32], -512);

        // Two banks at full rate, then a third write while bank 0 still reads.
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        nb0 = nb;
        send(96, 1'b1, 0);
        chk("ovf_before", int'(bus.overflow), 0);
        send(1, 1'b0, 1500);
        chk("ovf_after", int'(bus.overflow), 1);
        wait_nb(nb0 + 2, "ovf_bursts");
        chk("ovf_bank0_b1", b1[nb0 % 32], 24);
        chk("ovf_bank1_b1", b1[(nb0 + 1) % 32], 72);

        // Reset at bin 30 aborts the burst; a fresh frame then runs normally.
        nb0 = nb;
        ns0 = nstart;
        send(48, 1'b1, 200);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.valid_out && bus.bin_idx == 6'd30) break;
        end
        chk("abort_reach_bin30", int'(bus.bin_idx), 30);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", int'(bus.valid_out), 0);
        chk("abort_ovf", int'(bus.overflow), 0);
        @(negedge clk) reset = 1'b0;
        repeat (80) @(posedge clk);
        chk("abort_no_restart", nstart - ns0, 1);
        chk("abort_no_complete", nb - nb0, 0);
        send(48, 1'b1, 400);
        wait_nb(nb0 + 1, "post_reset_bursts");
        chk("post_reset_b1", b1[nb0 % 32], 424);
        chk("post_reset_p7", p7[nb0 % 32], 512);
        chk("post_reset_p21", p21[nb0 % 32], -512);
        chk("stream_framing", seq_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
